// File: rtl/hcp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hcp_pkg
// Purpose  : Shared encodings for the host-side frame packer: word flags,
//            discard reasons, metadata field offsets and FSM states.
// Revision : 1.0 - initial parametrised release
// ============================================================================
package hcp_pkg;

  // Two-bit word flag field: bit 0 marks the first word, bit 1 the last
  localparam logic [1:0] FLAG_MID   = 2'b00;
  localparam logic [1:0] FLAG_FIRST = 2'b01;
  localparam logic [1:0] FLAG_LAST  = 2'b10;

  // Discard reason codes carried in the metadata word
  localparam logic [1:0] RSN_NONE = 2'b00;
  localparam logic [1:0] RSN_RUNT = 2'b01;
  localparam logic [1:0] RSN_LONG = 2'b10;
  localparam logic [1:0] RSN_ERR  = 2'b11;

  // Metadata word layout
  localparam int META_PORT_LSB = 60;
  localparam int META_LEN_LSB  = 48;
  localparam int META_DISC_BIT = 47;
  localparam int META_RSN_LSB  = 45;
  localparam int META_TS_LSB   = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PACK = 2'd1,
    DROP = 2'd2
  } state_t;

  // Highest-priority reason wins: a corrupted frame is reported as ERR even
  // when it was also truncated or short.
  function automatic logic [1:0] pick_reason(input logic err, input logic long_f,
                                             input logic runt);
    if (err)         return RSN_ERR;
    else if (long_f) return RSN_LONG;
    else if (runt)   return RSN_RUNT;
    else             return RSN_NONE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hcp_frame_packer_if.sv
`default_nettype none
// ============================================================================
// Module   : hcp_frame_packer_if
// Purpose  : Byte-stream input and word/metadata output bundle of the frame
//            packer. The master side drives bytes, the slave side packs them.
// Revision : 1.0 - initial parametrised release
// ============================================================================
interface hcp_frame_packer_if #(
  parameter int DATA_BYTES = 16
);
  logic [8:0]              iv_data;
  logic                    i_data_wr;
  logic                    i_data_er;
  logic                    i_fifo_afull;
  logic [8*DATA_BYTES+5:0] ov_data;
  logic                    o_data_wr;
  logic [63:0]             ov_metadata;
  logic                    o_metadata_wr;
  logic                    o_drop_pulse;

  modport master (
    output iv_data, i_data_wr, i_data_er, i_fifo_afull,
    input  ov_data, o_data_wr, ov_metadata, o_metadata_wr, o_drop_pulse
  );

  modport slave (
    input  iv_data, i_data_wr, i_data_er, i_fifo_afull,
    output ov_data, o_data_wr, ov_metadata, o_metadata_wr, o_drop_pulse
  );
endinterface
`default_nettype wire

// File: rtl/hcp_lane_assembler.sv
`default_nettype none
// ============================================================================
// Module   : hcp_lane_assembler
// Purpose  : Places accepted bytes into successive lanes of a word (first
//            byte in the MSBs), and registers the word with its flag and
//            invalid-byte count when the word fills or the frame closes.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module hcp_lane_assembler #(
  parameter int DATA_BYTES = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_vld,    // byte accepted this cycle
  input  logic                    i_start,  // byte is the first of a frame
  input  logic                    i_close,  // byte is the last kept byte
  input  logic [7:0]              i_byte,
  output logic [8*DATA_BYTES+5:0] o_word,
  output logic                    o_word_wr
);
  import hcp_pkg::*;

  localparam int              W         = 8 * DATA_BYTES;
  localparam int              LW        = $clog2(DATA_BYTES);
  localparam logic [LW-1:0]   LAST_LANE = LW'(DATA_BYTES - 1);

  logic [LW-1:0] r_lane;
  logic [W-1:0]  r_buf;
  logic          r_first_pend;

  logic [LW-1:0] w_lane;
  logic [W-1:0]  w_buf;
  logic          w_full;
  logic          w_emit;
  logic [1:0]    w_flags;
  logic [3:0]    w_inv;

  // Insert the byte into its lane; a new frame always restarts at lane 0
  // with an empty buffer so unused lanes of a short word read as zero.
  always_comb begin
    w_lane  = i_start ? '0 : r_lane;
    w_buf   = i_start ? '0 : r_buf;
    w_buf[W - 8 - 8 * int'(w_lane) +: 8] = i_byte;
    w_full  = (w_lane == LAST_LANE);
    w_emit  = i_vld && (w_full || i_close);
    w_flags = ((i_start || r_first_pend) ? FLAG_FIRST : FLAG_MID) |
              (i_close ? FLAG_LAST : FLAG_MID);
    w_inv   = w_full ? 4'd0 : 4'(LAST_LANE - w_lane);
  end

  // Lane index, partial-word buffer and pending first-word marker
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lane       <= '0;
      r_buf        <= '0;
      r_first_pend <= 1'b0;
    end else if (i_vld) begin
      if (w_emit) begin
        r_lane       <= '0;
        r_buf        <= '0;
        r_first_pend <= 1'b0;
      end else begin
        r_lane       <= w_lane + LW'(1);
        r_buf        <= w_buf;
        r_first_pend <= i_start | r_first_pend;
      end
    end
  end

  // Registered word output, valid one cycle after its completing byte
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_word    <= '0;
      o_word_wr <= 1'b0;
    end else begin
      o_word_wr <= w_emit;
      if (w_emit) o_word <= {w_flags, w_inv, w_buf};
    end
  end

endmodule
`default_nettype wire

// File: rtl/hcp_frame_packer.sv
`default_nettype none
// ============================================================================
// Module   : hcp_frame_packer
// Purpose  : Packs a core-domain byte stream into DATA_BYTES-wide words and
//            emits one metadata word per frame with length, inport,
//            timestamp and discard verdict. Polices min/max length, flags
//            GMII errors and drops whole frames when the FIFO is almost full.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module hcp_frame_packer #(
  parameter int         DATA_BYTES = 16,
  parameter logic [3:0] PORT_ID    = 4'd0,
  parameter int         MIN_LEN    = 60,
  parameter int         MAX_LEN    = 1518
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  hcp_frame_packer_if.slave io
);
  import hcp_pkg::*;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [11:0] r_len;
  logic        r_err;
  logic [31:0] r_ts;
  logic [31:0] r_ts_lat;
  logic [63:0] r_meta;
  logic        r_meta_wr;
  logic        r_drop;

  logic        w_last;
  logic        w_acc_first;
  logic        w_acc;
  logic        w_trunc;
  logic        w_close;
  logic        w_drop;
  logic [11:0] w_len_next;
  logic        w_err_next;
  logic [31:0] w_ts_frame;
  logic [1:0]  w_rsn;
  logic [63:0] w_meta;
  logic [8*DATA_BYTES+5:0] w_word;
  logic        w_word_wr;

  // Acceptance, policing, metadata assembly and next-state selection
  always_comb begin
    w_last      = io.iv_data[8];
    w_acc_first = (r_state == IDLE) && io.i_data_wr && !io.i_fifo_afull;
    w_acc       = w_acc_first || ((r_state == PACK) && io.i_data_wr);
    w_drop      = (r_state == IDLE) && io.i_data_wr && io.i_fifo_afull;
    w_len_next  = w_acc_first ? 12'd1 : (r_len + 12'd1);
    w_err_next  = (w_acc_first ? 1'b0 : r_err) | io.i_data_er;
    // Reaching the cap on a non-final byte cuts the frame here
    w_trunc     = w_acc && (w_len_next == 12'(MAX_LEN)) && !w_last;
    w_close     = w_acc && (w_last || w_trunc);
    w_ts_frame  = w_acc_first ? r_ts : r_ts_lat;
    w_rsn       = pick_reason(w_err_next, w_trunc, w_len_next < 12'(MIN_LEN));

    w_meta                          = '0;
    w_meta[META_PORT_LSB +: 4]      = PORT_ID;
    w_meta[META_LEN_LSB +: 12]      = w_len_next;
    w_meta[META_DISC_BIT]           = (w_rsn != RSN_NONE);
    w_meta[META_RSN_LSB +: 2]       = w_rsn;
    w_meta[META_TS_LSB +: 32]       = w_ts_frame;

    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (io.i_data_wr) begin
          // A single-byte frame refused for afull needs no DROP visit
          if (io.i_fifo_afull) w_state_nxt = w_last ? IDLE : DROP;
          else if (w_close)    w_state_nxt = w_trunc ? DROP : IDLE;
          else                 w_state_nxt = PACK;
        end
      end
      PACK: begin
        if (w_close) w_state_nxt = w_trunc ? DROP : IDLE;
      end
      DROP: begin
        if (io.i_data_wr && w_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Free-running timestamp counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_ts <= '0;
    else          r_ts <= r_ts + 32'd1;
  end

  // Per-frame context: length, sticky error, timestamp of the first byte
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_len    <= '0;
      r_err    <= 1'b0;
      r_ts_lat <= '0;
    end else begin
      if (w_acc) begin
        r_len <= w_len_next;
        r_err <= w_err_next;
      end
      if (w_acc_first) r_ts_lat <= r_ts;
    end
  end

  // Metadata and drop pulse, aligned with the registered last word
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta    <= '0;
      r_meta_wr <= 1'b0;
      r_drop    <= 1'b0;
    end else begin
      r_meta_wr <= w_close;
      r_drop    <= w_drop;
      if (w_close) r_meta <= w_meta;
    end
  end

  hcp_lane_assembler #(
    .DATA_BYTES (DATA_BYTES)
  ) u_lanes (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_vld     (w_acc),
    .i_start   (w_acc_first),
    .i_close   (w_close),
    .i_byte    (io.iv_data[7:0]),
    .o_word    (w_word),
    .o_word_wr (w_word_wr)
  );

  assign io.ov_data       = w_word;
  assign io.o_data_wr     = w_word_wr;
  assign io.ov_metadata   = r_meta;
  assign io.o_metadata_wr = r_meta_wr;
  assign io.o_drop_pulse  = r_drop;

endmodule
`default_nettype wire
